// File: rtl/pressure_sensor_reader.sv
// Periodically requests a sample from a serial pressure sensor and decodes its
// start/5-data/even-parity/stop frame into pData with pValid/pErr result pulses.
module pressure_sensor_reader #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned BIT_CYCLES    = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sData,
  output logic       sReq,
  output logic [4:0] pData,
  output logic       pValid,
  output logic       pErr,
  output logic [1:0] errCode,
  output logic       busy
);

  localparam int unsigned CMAX = (SAMPLE_PERIOD > BIT_CYCLES) ? SAMPLE_PERIOD : BIT_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX) + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_START, START, DATA, PARITY, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [2:0]      nbit_q, nbit_d;
  logic [4:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            sync1_q, sync2_q;
  logic            sreq_q, sreq_d;
  logic [4:0]      pdata_q, pdata_d;
  logic            pvalid_q, pvalid_d;
  logic            perr_q, perr_d;
  logic [1:0]      errcode_q, errcode_d;
  logic            bit_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      nbit_q    <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sreq_q    <= 1'b0;
      pdata_q   <= 5'b10000;
      pvalid_q  <= 1'b0;
      perr_q    <= 1'b0;
      errcode_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      nbit_q    <= nbit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      sync1_q   <= sData;
      sync2_q   <= sync1_q;
      sreq_q    <= sreq_d;
      pdata_q   <= pdata_d;
      pvalid_q  <= pvalid_d;
      perr_q    <= perr_d;
      errcode_q <= errcode_d;
    end
  end

  // cnt_q is shared: sample-period count in IDLE, cycles-within-bit elsewhere.
  assign bit_tick = (cnt_q == CW'(BIT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    nbit_d    = nbit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pdata_d   = pdata_q;
    pvalid_d  = 1'b0;
    perr_d    = 1'b0;
    errcode_d = errcode_q;

    case (state_q)
      IDLE: begin
        if (!en) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(SAMPLE_PERIOD - 1)) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REQ: begin
        if (bit_tick) begin
          state_d = WAIT_START;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_START: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          perr_d    = 1'b1;
          errcode_d = 2'b01;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      START: begin
        // A start bit that is no longer low at mid-bit was a glitch; the timeout keeps running.
        if (cnt_q == CW'(BIT_CYCLES / 2 - 1)) begin
          cnt_d   = '0;
          nbit_d  = '0;
          state_d = sync2_q ? WAIT_START : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {shift_q[3:0], sync2_q};
          nbit_d  = nbit_q + 3'd1;
          if (nbit_q == 3'd4) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = sync2_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!sync2_q) begin
            perr_d    = 1'b1;
            errcode_d = 2'b11;
          end else if (^{shift_q, par_q}) begin
            perr_d    = 1'b1;
            errcode_d = 2'b10;
          end else begin
            pdata_d  = shift_q;
            pvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    sreq_d = (state_d == REQ);
  end

  assign sReq    = sreq_q;
  assign pData   = pdata_q;
  assign pValid  = pvalid_q;
  assign pErr    = perr_q;
  assign errCode = errcode_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pressure_sensor_reader.sv
// Self-checking bench: acts as the sensor and predicts results and their timing
// from the frame rules (sync latency, mid-bit sampling, result one cycle later).
module tb_pressure_sensor_reader;

  localparam int SP = 20;
  localparam int BC = 4;
  localparam int TO = 16;
  // Start edge -> result pulse: 2 sync + half bit + 7 more bits + 1 registered result.
  localparam int FRAME_LAT = 2 + BC / 2 + 7 * BC + 1;
  localparam int POST      = FRAME_LAT + SP;

  logic       clk = 1'b0;
  logic       rst, en, sData;
  logic       sReq, pValid, pErr, busy;
  logic [4:0] pData;
  logic [1:0] errCode;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_pdata;
  logic [1:0] exp_err;

  pressure_sensor_reader #(
    .SAMPLE_PERIOD(SP),
    .BIT_CYCLES   (BC),
    .TIMEOUT      (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sData  (sData),
    .sReq   (sReq),
    .pData  (pData),
    .pValid (pValid),
    .pErr   (pErr),
    .errCode(errCode),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (sReq !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (sReq !== 1'b1) begin
      errors++;
      $display("FAIL req_rise: sReq=%b after %0d cycles, expected 1", sReq, n);
    end
    n = 0;
    while (sReq === 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n != BC) begin
      errors++;
      $display("FAIL req_width: sReq high %0d cycles, expected %0d", n, BC);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sData = 1'b1;
    exp_pdata = 5'b10000; exp_err = 2'b00;
    #2;
    tick(); tick();
    checks++;
    if (pData !== 5'b10000 || sReq !== 1'b0 || busy !== 1'b0 || pValid !== 1'b0 ||
        pErr !== 1'b0 || errCode !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: pData=%b sReq=%b busy=%b pValid=%b pErr=%b errCode=%b, expected 10000 0 0 0 0 00",
               pData, sReq, busy, pValid, pErr, errCode);
    end
    rst = 1'b0;
    for (int i = 1; i <= SP; i++) begin
      tick();
      checks++;
      if (sReq !== (i == SP) || busy !== (i == SP)) begin
        errors++;
        $display("FAIL reset_first_req: cycle %0d sReq=%b busy=%b, expected %b", i, sReq, busy, (i == SP));
      end
    end
  endtask

  task automatic test_timeout();
    wait_req();
    for (int j = 1; j <= TO + SP; j++) begin
      tick();
      if (j == TO) exp_err = 2'b01;
      checks++;
      if (pErr !== (j == TO) || pValid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse: cycle %0d pErr=%b pValid=%b, expected %b 0", j, pErr, pValid, (j == TO));
      end
      checks++;
      if (errCode !== exp_err || pData !== exp_pdata) begin
        errors++;
        $display("FAIL timeout_hold: cycle %0d errCode=%b pData=%b, expected %b %b", j, errCode, pData, exp_err, exp_pdata);
      end
      checks++;
      if (sReq !== (j == TO + SP) || busy !== (j < TO || j == TO + SP)) begin
        errors++;
        $display("FAIL timeout_next_req: cycle %0d sReq=%b busy=%b, expected %b %b",
                 j, sReq, busy, (j == TO + SP), (j < TO || j == TO + SP));
      end
    end
  endtask

  // d: cycles after sReq falls before the start bit; glitch: one-cycle low pulse first.
  task automatic send_frame(input logic [4:0] data, input logic par, input logic stp,
                            input int d, input bit glitch, input bit drop_en, input bit noise);
    logic       fb [8];
    logic       exp_v, exp_e;
    logic [1:0] code;
    int         pre;
    fb[0] = 1'b0;
    for (int i = 0; i < 5; i++) fb[i+1] = data[4-i];
    fb[6] = par;
    fb[7] = stp;
    exp_v = 1'b0; exp_e = 1'b0; code = 2'b00;
    if (!stp) begin
      exp_e = 1'b1; code = 2'b11;
    end else if ((($countones(data) + int'(par)) % 2) != 0) begin
      exp_e = 1'b1; code = 2'b10;
    end else begin
      exp_v = 1'b1;
    end

    wait_req();
    pre = 0;
    if (glitch) begin
      sData = 1'b0;
      tick();
      sData = 1'b1;
      pre = 1;
    end
    for (int k = pre; k < d; k++) begin
      tick();
      checks++;
      if (pValid !== 1'b0 || pErr !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pre_frame: pValid=%b pErr=%b busy=%b, expected 0 0 1", pValid, pErr, busy);
      end
    end
    sData = fb[0];

    for (int j = 1; j <= POST; j++) begin
      tick();
      if (j == FRAME_LAT) begin
        if (exp_v) exp_pdata = data;
        if (exp_e) exp_err = code;
      end
      checks++;
      if (pValid !== (exp_v && j == FRAME_LAT) || pErr !== (exp_e && j == FRAME_LAT)) begin
        errors++;
        $display("FAIL frame_pulse: data=%b par=%b stop=%b cycle %0d pValid=%b pErr=%b, expected %b %b",
                 data, par, stp, j, pValid, pErr, (exp_v && j == FRAME_LAT), (exp_e && j == FRAME_LAT));
      end
      checks++;
      if (pData !== exp_pdata || errCode !== exp_err) begin
        errors++;
        $display("FAIL frame_outputs: data=%b par=%b stop=%b cycle %0d pData=%b errCode=%b, expected %b %b",
                 data, par, stp, j, pData, errCode, exp_pdata, exp_err);
      end
      checks++;
      if (sReq !== (j == POST && !drop_en) ||
          busy !== (j < FRAME_LAT || (j == POST && !drop_en))) begin
        errors++;
        $display("FAIL frame_req_busy: cycle %0d sReq=%b busy=%b, expected %b %b", j, sReq, busy,
                 (j == POST && !drop_en), (j < FRAME_LAT || (j == POST && !drop_en)));
      end
      if (drop_en && j == 10) en = 1'b0;
      if (j < 32)                      sData = fb[j / BC];
      else if (noise && j < POST)      sData = 1'($urandom);
      else                             sData = 1'b1;
    end

    if (drop_en) begin
      en = 1'b1;
      for (int i = 1; i <= SP; i++) begin
        tick();
        checks++;
        if (sReq !== (i == SP)) begin
          errors++;
          $display("FAIL en_resume: cycle %0d sReq=%b, expected %b", i, sReq, (i == SP));
        end
      end
    end
  endtask

  task automatic test_good_frame();
    send_frame(5'b10110, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_parity_error();
    send_frame(5'b10110, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_framing();
    send_frame(5'b01101, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    send_frame(5'b01101, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    send_frame(5'b00111, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_en_hold();
    send_frame(5'b11000, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [4:0] data;
    logic       par, stp;
    int         d;
    bit         gl;
    for (int n = 0; n < 16; n++) begin
      data = 5'($urandom);
      par  = ^data;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp  = ($urandom_range(0, 4) != 0);
      gl   = ($urandom_range(0, 3) == 0);
      d    = gl ? $urandom_range(6, TO - 3) : $urandom_range(0, TO - 3);
      send_frame(data, par, stp, d, gl, 1'b0, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_data();
    logic [4:0] data;
    data = 5'b10101;
    wait_req();
    tick(); tick();
    sData = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      tick();
      sData = (j < BC) ? 1'b0 : data[4 - (j / BC - 1)];
    end
    rst = 1'b1;
    #1;
    exp_pdata = 5'b10000;
    exp_err   = 2'b00;
    checks++;
    if (pData !== exp_pdata || errCode !== exp_err || pValid !== 1'b0 || pErr !== 1'b0 ||
        busy !== 1'b0 || sReq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values: pData=%b errCode=%b pValid=%b pErr=%b busy=%b sReq=%b, expected 10000 00 0 0 0 0",
               pData, errCode, pValid, pErr, busy, sReq);
    end
    tick();
    rst = 1'b0;
    sData = 1'b1;
    for (int i = 1; i <= SP; i++) begin
      tick();
      checks++;
      if (pValid !== 1'b0 || pErr !== 1'b0 || sReq !== (i == SP)) begin
        errors++;
        $display("FAIL mid_reset_after: cycle %0d pValid=%b pErr=%b sReq=%b, expected 0 0 %b",
                 i, pValid, pErr, sReq, (i == SP));
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_good_frame();
    test_parity_error();
    test_framing();
    test_glitch();
    test_en_hold();
    test_random();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
